key_buffer: RTL and testbench
=============================

KEY_BUFFER -- requirements
Module: key_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4..64.
REQ-002 Parameter ENTER_CODE, default 8'h5A, scan code that starts playback.
REQ-003 Parameter BKSP_CODE, default 8'h66, scan code that deletes the newest entry.
REQ-004 clk  input  1  single system clock; all logic SHALL be rising-edge triggered on it.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 scan_code  input  8  received scan code from the PS/2 controller.
REQ-007 scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-008 rd_req  input  1  morse encoder consumes the presented character.
REQ-009 char_code  output  8  head-of-FIFO scan code.
REQ-010 char_valid  output  1  char_code is valid and may be consumed.
REQ-011 playing  output  1  high while in PLAY.
REQ-012 play_done  output  1  one-cycle pulse when playback drains the FIFO.
REQ-013 full  output  1  occupancy equals DEPTH.
REQ-014 empty  output  1  occupancy equals 0.
REQ-015 overflow  output  1  sticky; a store was attempted while full.

Function
REQ-016 States SHALL be COLLECT, BREAK and PLAY; occupancy counter width SHALL be log2(DEPTH)+1.
REQ-017 COLLECT, scan_valid, code 8'hE0: discard; no state change.
REQ-018 COLLECT, scan_valid, code 8'hF0: discard; go to BREAK.
REQ-019 BREAK, next scan_valid: discard that code, whatever its value (including F0, E0 or ENTER_CODE); return to COLLECT.
REQ-020 COLLECT, scan_valid, ENTER_CODE: not stored; go to PLAY next cycle if not empty; if empty, pulse play_done next cycle and remain in COLLECT.
REQ-021 COLLECT, scan_valid, BKSP_CODE: not stored; remove the newest entry (write pointer and count decrement); no effect if empty.
REQ-022 COLLECT, scan_valid, any other code: write at the write pointer, pointer and count increment; visible in count next cycle.
REQ-023 Store while full: data dropped, pointers unchanged, overflow set next cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH.
REQ-025 char_valid = (state == PLAY) and not empty; char_code = entry at the read pointer (show-ahead, no read latency).
REQ-026 rd_req with char_valid high: pop; the next entry is presented in the following cycle.
REQ-027 rd_req with char_valid low: ignored.
REQ-028 Pop of the last entry: play_done pulses in the next cycle; state returns to COLLECT in the same cycle.
REQ-029 PLAY: every scan_valid is discarded, including F0 and E0; BREAK is not entered.
REQ-030 rd_req and scan_valid in the same cycle: the rule for the current state applies to each independently; no combined effect.
REQ-031 full and empty SHALL be registered-consistent with the count in every cycle.

Reset
REQ-032 While rst is high at a rising edge: state COLLECT; pointers and count 0; char_valid 0; playing 0; play_done 0; full 0; empty 1; overflow 0.
REQ-033 Reset mid-PLAY or mid-BREAK SHALL abandon all contents; FIFO memory contents need no reset.

Verification
REQ-034 Codes 1C, 29, 32, then 5A; rd_req each cycle while char_valid -> char_code 1C, 29, 32 in order; play_done one cycle after the third pop; empty=1.
REQ-035 Codes 1C, F0, 1C, 21, then 5A -> playback yields 1C, 21 only.
REQ-036 DEPTH=16; 17 codes of 32 -> full=1, overflow=1, count 16; after 5A, exactly 16 pops before play_done.
REQ-037 Codes 1C, 32, 66, 21, then 5A -> playback yields 1C, 21; 66 on empty FIFO -> no change, empty=1.
REQ-038 During PLAY, code 1C arrives in the same cycle as rd_req -> pop occurs, 1C not stored, count decrements by exactly 1.
REQ-039 rst asserted mid-PLAY with 3 entries -> next cycle empty=1, playing=0, char_valid=0; a fresh 1C then 5A plays 1C.

Source files
------------

// File: rtl/key_buffer.sv
// Key buffer: collects PS/2 make codes into a FIFO, filters break/extended
// prefixes and backspace edits, and replays the contents once ENTER arrives.
module key_buffer #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] ENTER_CODE = 8'h5A,
    parameter logic [7:0] BKSP_CODE  = 8'h66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       rd_req,
    output logic [7:0] char_code,
    output logic       char_valid,
    output logic       playing,
    output logic       play_done,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [7:0]       CODE_EXT   = 8'hE0;
    localparam logic [7:0]       CODE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_BREAK   = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nx_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nx_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             wr_en_s;
    logic             done_nx_s;
    logic             ovf_nx_s;
    logic [7:0]       char_code_r;
    logic             char_valid_r;
    logic             playing_r;
    logic             play_done_r;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;

    assign char_code  = char_code_r;
    assign char_valid = char_valid_r;
    assign playing    = playing_r;
    assign play_done  = play_done_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign overflow   = overflow_r;

    // Next-state decode for the FSM, pointers, occupancy and status flags
    always_comb begin
        state_nx_s  = state_r;
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        count_nx_s  = count_r;
        wr_en_s     = 1'b0;
        done_nx_s   = 1'b0;
        ovf_nx_s    = overflow_r;
        case (state_r)
            ST_COLLECT: begin
                if (scan_valid) begin
                    case (scan_code)
                        CODE_EXT:   state_nx_s = ST_COLLECT;
                        CODE_BREAK: state_nx_s = ST_BREAK;
                        ENTER_CODE: begin
                            // ENTER on an empty buffer completes an empty playback at once
                            if (empty_r) begin
                                done_nx_s = 1'b1;
                            end else begin
                                state_nx_s = ST_PLAY;
                            end
                        end
                        BKSP_CODE: begin
                            if (!empty_r) begin
                                wr_ptr_nx_s = wr_ptr_r - PTR_ONE;
                                count_nx_s  = count_r - CNT_ONE;
                            end else begin
                                count_nx_s = count_r;
                            end
                        end
                        default: begin
                            if (full_r) begin
                                ovf_nx_s = 1'b1;
                            end else begin
                                wr_en_s     = 1'b1;
                                wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
                                count_nx_s  = count_r + CNT_ONE;
                            end
                        end
                    endcase
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_BREAK: begin
                if (scan_valid) begin
                    state_nx_s = ST_COLLECT;
                end else begin
                    state_nx_s = ST_BREAK;
                end
            end
            ST_PLAY: begin
                // Scan codes arriving during playback are dropped; only pops matter
                if (rd_req && char_valid_r) begin
                    rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
                    count_nx_s  = count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        state_nx_s = ST_COLLECT;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_PLAY;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            default: begin
                state_nx_s = ST_COLLECT;
            end
        endcase
    end

    // FSM state, pointers, count and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_COLLECT;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            char_code_r  <= 8'h00;
            char_valid_r <= 1'b0;
            playing_r    <= 1'b0;
            play_done_r  <= 1'b0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            wr_ptr_r     <= wr_ptr_nx_s;
            rd_ptr_r     <= rd_ptr_nx_s;
            count_r      <= count_nx_s;
            // Show-ahead head register; bypass covers a write landing on the head slot
            char_code_r  <= (wr_en_s && (wr_ptr_r == rd_ptr_nx_s)) ? scan_code
                                                                    : mem_r[rd_ptr_nx_s];
            char_valid_r <= (state_nx_s == ST_PLAY) && (count_nx_s != CNT_ZERO);
            playing_r    <= (state_nx_s == ST_PLAY);
            play_done_r  <= done_nx_s;
            full_r       <= (count_nx_s == CNT_FULL);
            empty_r      <= (count_nx_s == CNT_ZERO);
            overflow_r   <= ovf_nx_s;
        end
    end

    // FIFO storage; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= scan_code;
        end
    end

endmodule

// File: tb/tb_key_buffer.sv
// Directed self-checking bench for key_buffer (DEPTH = 16).
module tb_key_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       rd_req;
    logic [7:0] char_code;
    logic       char_valid;
    logic       playing;
    logic       play_done;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks;
    int errors;

    logic [7:0] got_q[$];
    int         pops;
    bit         done_seen;

    key_buffer #(
        .DEPTH(16),
        .ENTER_CODE(8'h5A),
        .BKSP_CODE(8'h66)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan_code(scan_code),
        .scan_valid(scan_valid),
        .rd_req(rd_req),
        .char_code(char_code),
        .char_valid(char_valid),
        .playing(playing),
        .play_done(play_done),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Present one scan code for a single cycle; returns 1 time unit after the edge
    task automatic send(input logic [7:0] code);
        scan_code  = code;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    // Pop while char_valid, recording presented codes, until play_done or budget
    task automatic drain();
        got_q.delete();
        pops      = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (char_valid) begin
                got_q.push_back(char_code);
                rd_req = 1'b1;
                pops++;
            end else begin
                rd_req = 1'b0;
            end
            @(posedge clk);
            #1;
            rd_req = 1'b0;
            if (play_done) done_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({empty, full, char_valid, playing, play_done, overflow} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {empty, full, char_valid, playing, play_done, overflow});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_playback();
        logic [7:0] exp_a [3] = '{8'h1C, 8'h29, 8'h32};
        // ENTER with nothing buffered: immediate play_done, no playback
        send(8'h5A);
        checks++;
        if ({play_done, playing} !== 2'b10) begin
            errors++;
            $display("FAIL empty_enter: got done/playing %b expected 10", {play_done, playing});
        end
        send(8'h1C);
        send(8'h29);
        send(8'h32);
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_not_empty: got %b expected 0", empty);
        end
        send(8'h5A);
        checks++;
        if ({playing, char_valid, char_code} !== {2'b11, 8'h1C}) begin
            errors++;
            $display("FAIL basic_head: got %b %b %h expected 1 1 1c", playing, char_valid, char_code);
        end
        drain();
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL basic_char%0d: got %h expected %h", i, got_q[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (!done_seen || pops != 3 || empty !== 1'b1 || playing !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%0d pops=%0d empty=%b playing=%b expected 1 3 1 0",
                     done_seen, pops, empty, playing);
        end
        @(posedge clk);
        #1;
        checks++;
        if (play_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b expected 0", play_done);
        end
    endtask

    task automatic test_break();
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'h21);
        send(8'h5A);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'h1C || got_q[1] !== 8'h21) begin
            errors++;
            $display("FAIL break_filter: got %0d codes first %h expected 2 codes 1c 21",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        end
        // ENTER following a break prefix is swallowed and must not start playback
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        checks++;
        if ({playing, play_done, empty} !== 3'b001) begin
            errors++;
            $display("FAIL break_enter: got %b expected 001", {playing, play_done, empty});
        end
    endtask

    task automatic test_backspace();
        send(8'h66);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL bksp_empty: got empty=%b full=%b expected 1 0", empty, full);
        end
        send(8'h1C);
        send(8'h32);
        send(8'h66);
        send(8'h21);
        send(8'h5A);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'h1C || got_q[1] !== 8'h21) begin
            errors++;
            $display("FAIL bksp_edit: got %0d codes last %h expected 2 codes 1c 21",
                     got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00);
        end
    endtask

    task automatic test_play_collision();
        send(8'h1C);
        send(8'h29);
        send(8'h5A);
        // Scan code and pop in the same cycle: pop only
        scan_code  = 8'h1C;
        scan_valid = 1'b1;
        rd_req     = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        rd_req     = 1'b0;
        checks++;
        if ({char_valid, char_code} !== {1'b1, 8'h29}) begin
            errors++;
            $display("FAIL collide_head: got %b %h expected 1 29", char_valid, char_code);
        end
        send(8'hF0);
        checks++;
        if ({playing, char_code} !== {1'b1, 8'h29}) begin
            errors++;
            $display("FAIL play_ignores_f0: got %b %h expected 1 29", playing, char_code);
        end
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h29 || !done_seen) begin
            errors++;
            $display("FAIL collide_drain: got %0d codes done=%0d expected 1 code 29 done=1",
                     got_q.size(), done_seen);
        end
        // F0 during playback must not have left a pending break behind
        send(8'h1C);
        send(8'h5A);
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h1C) begin
            errors++;
            $display("FAIL post_play_collect: got %0d codes expected 1 code 1c", got_q.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send(8'h32);
        checks++;
        if ({full, overflow, empty} !== 3'b100) begin
            errors++;
            $display("FAIL fill16: got full/ovf/empty %b expected 100", {full, overflow, empty});
        end
        send(8'h32);
        checks++;
        if ({full, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_set: got %b expected 11", {full, overflow});
        end
        send(8'h5A);
        drain();
        checks++;
        if (!done_seen || pops != 16) begin
            errors++;
            $display("FAIL overflow_pops: got done=%0d pops=%0d expected 1 16", done_seen, pops);
        end
        checks++;
        if ({overflow, empty, full} !== 3'b110) begin
            errors++;
            $display("FAIL overflow_sticky: got %b expected 110", {overflow, empty, full});
        end
    endtask

    task automatic test_reset_mid_play();
        send(8'h1C);
        send(8'h29);
        send(8'h32);
        send(8'h5A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({empty, playing, char_valid, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_play: got %b expected 1000",
                     {empty, playing, char_valid, overflow});
        end
        send(8'h1C);
        send(8'h5A);
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h1C || !done_seen) begin
            errors++;
            $display("FAIL reset_fresh_play: got %0d codes done=%0d expected 1 code 1c done=1",
                     got_q.size(), done_seen);
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        rd_req     = 1'b0;
        checks     = 0;
        errors     = 0;
        test_reset();
        test_basic_playback();
        test_break();
        test_backspace();
        test_play_collision();
        test_overflow();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
